// File: rtl/seq_shift_add_mult8_if.sv
// Operand/product handshake bundle for the sequential shift-and-add multiplier.
// The producer/consumer side uses the master modport, the multiplier uses slave.
interface seq_shift_add_mult8_if #(
  parameter int WIDTH = 8
);
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic                 out_valid;
  logic                 out_ready;
  logic [2*WIDTH-1:0]   product;
  logic                 busy;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, product, busy
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, product, busy
  );
endinterface

// File: rtl/seq_shift_add_mult8.sv
// Iterative unsigned radix-2 shift-and-add multiplier.
// One partial-product addition per clock through a generate/propagate carry
// adder; an operand pair is accepted in IDLE, WIDTH BUSY edges build the
// product in {ACC, Q}, and the result is presented in DONE until taken.
module seq_shift_add_mult8 #(
  parameter int WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst,
  seq_shift_add_mult8_if.slave bus
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);
  localparam logic [CW-1:0] ONE_CNT   = CW'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state_r;
  logic [WIDTH-1:0]     m_r;
  logic [WIDTH-1:0]     acc_r;
  logic [WIDTH-1:0]     q_r;
  logic [CW-1:0]        count_r;
  logic                 out_valid_r;
  logic                 busy_r;
  logic [2*WIDTH-1:0]   product_r;

  logic [WIDTH:0]       sum_s;
  logic [WIDTH-1:0]     acc_next_s;
  logic [WIDTH-1:0]     q_next_s;
  logic                 last_s;

  // WIDTH + WIDTH -> WIDTH+1 add using generate/propagate carry terms;
  // the carry out lands in the top bit so nothing is lost.
  function automatic logic [WIDTH:0] cla_add(
    input logic [WIDTH-1:0] x,
    input logic [WIDTH-1:0] y
  );
    logic [WIDTH-1:0] g;
    logic [WIDTH-1:0] p;
    logic [WIDTH:0]   c;
    g = x & y;
    p = x ^ y;
    c = {(WIDTH + 1){1'b0}};
    for (int i = 0; i < WIDTH; i++) begin
      c[i+1] = g[i] | (p[i] & c[i]);
    end
    return {c[WIDTH], p ^ c[WIDTH-1:0]};
  endfunction

  // Partial-product step: add M when the current multiplier bit is set,
  // then shift the WIDTH+1-bit sum right into {ACC, Q}.
  always_comb begin
    sum_s = {(WIDTH + 1){1'b0}};
    if (q_r[0]) begin
      sum_s = cla_add(acc_r, m_r);
    end else begin
      sum_s = {1'b0, acc_r};
    end
    acc_next_s = sum_s[WIDTH:1];
    q_next_s   = {sum_s[0], q_r[WIDTH-1:1]};
    last_s     = (count_r == LAST_ITER);
  end

  // Control FSM and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      m_r         <= {WIDTH{1'b0}};
      acc_r       <= {WIDTH{1'b0}};
      q_r         <= {WIDTH{1'b0}};
      count_r     <= {CW{1'b0}};
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
      product_r   <= {(2 * WIDTH){1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.in_valid) begin
            m_r     <= bus.a;
            q_r     <= bus.b;
            acc_r   <= {WIDTH{1'b0}};
            count_r <= {CW{1'b0}};
            busy_r  <= 1'b1;
            state_r <= BUSY;
          end else begin
            state_r <= IDLE;
          end
        end
        BUSY: begin
          acc_r   <= acc_next_s;
          q_r     <= q_next_s;
          count_r <= count_r + ONE_CNT;
          if (last_s) begin
            product_r   <= {acc_next_s, q_next_s};
            out_valid_r <= 1'b1;
            busy_r      <= 1'b0;
            state_r     <= DONE;
          end else begin
            state_r <= BUSY;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_r <= 1'b0;
            state_r     <= IDLE;
          end else begin
            state_r <= DONE;
          end
        end
        default: begin
          out_valid_r <= 1'b0;
          busy_r      <= 1'b0;
          state_r     <= IDLE;
        end
      endcase
    end
  end

  // Acceptance is gated by rst so no operand is taken on a reset edge.
  assign bus.in_ready  = (state_r == IDLE) && !rst;
  assign bus.out_valid = out_valid_r;
  assign bus.product   = product_r;
  assign bus.busy      = busy_r;

endmodule
